// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   WIDTH_DEF / NCH_DEF : default counter width and channel count
//   TOP_RST / DUTY_RST  : reset values for TOP and duty registers. They are
//                         wide so they can be sliced to any WIDTH up to 64.
//   dir_e               : count direction of the center-aligned counter
package pwm_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NCH_DEF   = 4;

  localparam logic [63:0] TOP_RST  = '1;
  localparam logic [63:0] DUTY_RST = '0;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: a pending duty register, an active duty register and a
// registered compare.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   xfer       : period-boundary strobe; moves pending duty into active duty
//   wr, val    : duty write strobe and value, already decoded for this channel
//   en         : channel enable, applied directly at the output register
//   cnt        : shared period counter
//   pwm        : registered PWM output
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             xfer,
  input  logic             wr,
  input  logic [WIDTH-1:0] val,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_pend;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] duty_pend_nxt;

  // A write landing on the boundary cycle passes straight through to the
  // active register, so it governs the very next period.
  assign duty_pend_nxt = wr ? val : duty_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_pend <= DUTY_RST[WIDTH-1:0];
      duty_act  <= DUTY_RST[WIDTH-1:0];
      pwm       <= 1'b0;
    end else begin
      duty_pend <= duty_pend_nxt;
      if (xfer) begin
        duty_act <= duty_pend_nxt;
      end
      pwm <= en & (cnt < duty_act);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with one shared period counter and
// double-buffered TOP/duty registers that update only at a period boundary.
// Optional build macro PWM_CENTER_ALIGN_EN adds the center_mode input
// (up/down counting, symmetric pulses).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   ch_en[NCH]        : per-channel output enable
//   duty_wr/ch/val    : duty write strobe, target channel, value
//   top_wr/top_val    : TOP write strobe and value (period = TOP+1 in edge mode)
//   center_mode       : (PWM_CENTER_ALIGN_EN only) 1 = up/down counting
//   pwm_out[NCH]      : registered PWM outputs
//   period_start      : registered pulse on the first output cycle of a period
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  NCH   = NCH_DEF,
  localparam int CHW   = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_en,
  input  logic             duty_wr,
  input  logic [CHW-1:0]   duty_ch,
  input  logic [WIDTH-1:0] duty_val,
  input  logic             top_wr,
  input  logic [WIDTH-1:0] top_val,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic             center_mode,
`endif
  output logic [NCH-1:0]   pwm_out,
  output logic             period_start
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] top_act;
  logic [WIDTH-1:0] top_pend;
  logic [WIDTH-1:0] top_pend_nxt;
  logic             xfer;

  assign top_pend_nxt = top_wr ? top_val : top_pend;

`ifdef PWM_CENTER_ALIGN_EN
  logic mode_act;
  logic start;
  dir_e dir;
  dir_e dir_nxt;

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    dir_nxt = UP;
    // The first cycle after reset is also a boundary so center_mode and
    // fresh settings are picked up without waiting a full default period.
    xfer    = start;
    if (mode_act) begin
      xfer    = start | (cnt == '0);
      dir_nxt = dir;
      if (dir == UP) begin
        if (cnt >= top_act) begin
          // TOP=0 is degenerate in center mode; hold at zero.
          if (cnt != '0) begin
            dir_nxt = DOWN;
            cnt_nxt = cnt - 1'b1;
          end else begin
            cnt_nxt = cnt;
          end
        end
      end else begin
        cnt_nxt = cnt - 1'b1;
        // Turn around one step early so cnt==0 is seen exactly once.
        if (cnt == WIDTH'(1)) begin
          dir_nxt = UP;
        end
      end
    end else begin
      if (cnt == top_act) begin
        xfer    = 1'b1;
        cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_act <= 1'b0;
      start    <= 1'b1;
      dir      <= UP;
    end else begin
      start <= 1'b0;
      dir   <= dir_nxt;
      if (xfer) begin
        mode_act <= center_mode;
      end
    end
  end
`else
  always_comb begin
    cnt_nxt = cnt + 1'b1;
    xfer    = 1'b0;
    if (cnt == top_act) begin
      xfer    = 1'b1;
      cnt_nxt = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      top_pend     <= TOP_RST[WIDTH-1:0];
      top_act      <= TOP_RST[WIDTH-1:0];
      period_start <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      top_pend <= top_pend_nxt;
      if (xfer) begin
        top_act <= top_pend_nxt;
      end
      // Registered alongside the channel compares so it lines up with the
      // first output cycle of each period.
      period_start <= (cnt == '0);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .xfer (xfer),
      .wr   (duty_wr && (duty_ch == CHW'(i))),
      .val  (duty_val),
      .en   (ch_en[i]),
      .cnt  (cnt),
      .pwm  (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CHW   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   ch_en;
  logic             duty_wr;
  logic [CHW-1:0]   duty_ch;
  logic [WIDTH-1:0] duty_val;
  logic             top_wr;
  logic [WIDTH-1:0] top_val;
  logic             center_mode;
  logic [NCH-1:0]   pwm_out;
  logic             period_start;

  pwm_multi #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_en       (ch_en),
    .duty_wr     (duty_wr),
    .duty_ch     (duty_ch),
    .duty_val    (duty_val),
    .top_wr      (top_wr),
    .top_val     (top_val),
`ifdef PWM_CENTER_ALIGN_EN
    .center_mode (center_mode),
`endif
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: position inside the current period plus active and
  // pending settings, advanced once per clock from the edge-mode rules.
  int             m_cnt;
  int             m_top;
  int             m_pend_top;
  int             m_duty [NCH];
  int             m_pend [NCH];
  logic [NCH-1:0] exp_pwm;
  logic           exp_ps;

  task automatic model_reset();
    m_cnt      = 0;
    m_top      = 255;
    m_pend_top = 255;
    for (int i = 0; i < NCH; i++) begin
      m_duty[i] = 0;
      m_pend[i] = 0;
    end
    exp_pwm = '0;
    exp_ps  = 1'b0;
  endtask

  // One clock: outputs visible after this edge reflect the period position
  // before it; writes are taken before the boundary transfer.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NCH; i++) exp_pwm[i] = ch_en[i] && (m_cnt < m_duty[i]);
    exp_ps = (m_cnt == 0);
    if (duty_wr && int'(duty_ch) < NCH) m_pend[duty_ch] = int'(duty_val);
    if (top_wr) m_pend_top = int'(top_val);
    if (m_cnt == m_top) begin
      m_top = m_pend_top;
      for (int i = 0; i < NCH; i++) m_duty[i] = m_pend[i];
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    #1;
    duty_wr = 1'b0;
    top_wr  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (pwm_out !== '0) $display("FAIL reset_pwm got %b want 0000", pwm_out);
    else n_pass++;
    n_total++;
    if (period_start !== 1'b0) $display("FAIL reset_ps got %b want 0", period_start);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 520; k++) begin
      step();
      n_total++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps)
        $display("FAIL reset_run cyc %0d got pwm %b ps %b want pwm %b ps %b",
                 k, pwm_out, period_start, exp_pwm, exp_ps);
      else n_pass++;
    end
  endtask

  task automatic test_patterns();
    int hi [NCH];
    int ps_cnt;
    int dv [NCH];
    dv = '{3, 0, 10, 9};
    top_wr = 1'b1; top_val = 8'd9;
    step();
    for (int i = 0; i < NCH; i++) begin
      duty_wr = 1'b1; duty_ch = CHW'(i); duty_val = WIDTH'(dv[i]);
      step();
    end
    for (int k = 0; k < 300; k++) begin
      step();
      n_total++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps)
        $display("FAIL patterns cyc %0d got pwm %b ps %b want pwm %b ps %b",
                 k, pwm_out, period_start, exp_pwm, exp_ps);
      else n_pass++;
    end
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    ps_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
      ps_cnt += int'(period_start);
    end
    for (int i = 0; i < NCH; i++) begin
      n_total++;
      if (hi[i] !== ((dv[i] > 9) ? 10 : dv[i]))
        $display("FAIL patterns_hightime ch%0d got %0d want %0d", i, hi[i],
                 (dv[i] > 9) ? 10 : dv[i]);
      else n_pass++;
    end
    n_total++;
    if (ps_cnt !== 1) $display("FAIL patterns_ps_count got %0d want 1", ps_cnt);
    else n_pass++;
  endtask

  task automatic test_midwrite();
    for (int k = 0; k < 40 && m_cnt != 4; k++) step();
    duty_wr = 1'b1; duty_ch = 2'd0; duty_val = 8'd7;
    for (int k = 0; k < 25; k++) begin
      step();
      n_total++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps)
        $display("FAIL midwrite cyc %0d got pwm %b ps %b want pwm %b ps %b",
                 k, pwm_out, period_start, exp_pwm, exp_ps);
      else n_pass++;
    end
    for (int k = 0; k < 40 && m_cnt != 9; k++) step();
    duty_wr = 1'b1; duty_ch = 2'd0; duty_val = 8'd5;
    for (int k = 0; k < 25; k++) begin
      step();
      n_total++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps)
        $display("FAIL boundary_write cyc %0d got pwm %b ps %b want pwm %b ps %b",
                 k, pwm_out, period_start, exp_pwm, exp_ps);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    duty_wr = 1'b1; duty_ch = 2'd1; duty_val = 8'd8;
    for (int k = 0; k < 25; k++) step();
    for (int k = 0; k < 40 && m_cnt != 2; k++) step();
    ch_en[1] = 1'b0;
    step();
    n_total++;
    if (pwm_out[1] !== 1'b0) $display("FAIL enable_off got %b want 0", pwm_out[1]);
    else n_pass++;
    for (int k = 0; k < 15; k++) begin
      if (k == 7) ch_en[1] = 1'b1;
      step();
      n_total++;
      if (pwm_out !== exp_pwm)
        $display("FAIL enable cyc %0d got %b want %b", k, pwm_out, exp_pwm);
      else n_pass++;
    end
  endtask

  task automatic test_top0();
    top_wr = 1'b1; top_val = 8'd0;
    for (int k = 0; k < 30; k++) begin
      step();
      n_total++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps)
        $display("FAIL top0 cyc %0d got pwm %b ps %b want pwm %b ps %b",
                 k, pwm_out, period_start, exp_pwm, exp_ps);
      else n_pass++;
    end
    n_total++;
    if (period_start !== 1'b1) $display("FAIL top0_ps got %b want 1", period_start);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        duty_wr = 1'b1; duty_ch = CHW'($urandom_range(0, NCH-1));
        duty_val = WIDTH'($urandom_range(0, 14));
      end
      if ($urandom_range(0, 15) == 0) begin
        top_wr = 1'b1; top_val = WIDTH'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 15) == 0) ch_en = NCH'($urandom);
      step();
      n_total++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps)
        $display("FAIL random cyc %0d got pwm %b ps %b want pwm %b ps %b",
                 k, pwm_out, period_start, exp_pwm, exp_ps);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    ch_en = '1;
    top_wr = 1'b1; top_val = 8'd9;
    for (int k = 0; k < 4; k++) begin
      duty_wr = 1'b1; duty_ch = CHW'(k); duty_val = 8'd6;
      step();
    end
    for (int k = 0; k < 40; k++) step();
    for (int k = 0; k < 40 && m_cnt != 5; k++) step();
    duty_wr = 1'b1; duty_ch = 2'd2; duty_val = 8'd3;
    top_wr = 1'b1; top_val = 8'd4;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    duty_wr = 1'b0; top_wr = 1'b0;
    n_total++;
    if (pwm_out !== '0) $display("FAIL midreset_pwm got %b want 0000", pwm_out);
    else n_pass++;
    n_total++;
    if (period_start !== 1'b0) $display("FAIL midreset_ps got %b want 0", period_start);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      n_total++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps)
        $display("FAIL midreset_run cyc %0d got pwm %b ps %b want pwm %b ps %b",
                 k, pwm_out, period_start, exp_pwm, exp_ps);
      else n_pass++;
    end
  endtask

`ifdef PWM_CENTER_ALIGN_EN
  // Center mode: TOP=4, duty=2 gives an 8-cycle period with 3 high cycles
  // (cnt = 1,0,1 around the valley) and one period_start per period.
  task automatic test_center();
    logic [31:0] hist;
    int          hi;
    int          ps_cnt;
    center_mode = 1'b1;
    top_wr = 1'b1; top_val = 8'd4;
    for (int k = 0; k < 4; k++) begin
      duty_wr = 1'b1; duty_ch = CHW'(k); duty_val = 8'd2;
      @(posedge clk); #1; duty_wr = 1'b0; top_wr = 1'b0;
    end
    for (int k = 0; k < 300; k++) @(posedge clk);
    hi = 0; ps_cnt = 0; hist = '0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      hist[k] = pwm_out[0];
      hi += int'(pwm_out[0]);
      ps_cnt += int'(period_start);
    end
    n_total++;
    if (hi !== 12) $display("FAIL center_hightime got %0d want 12", hi);
    else n_pass++;
    n_total++;
    if (ps_cnt !== 4) $display("FAIL center_ps_count got %0d want 4", ps_cnt);
    else n_pass++;
    n_total++;
    if (hist[31:8] !== hist[23:0]) $display("FAIL center_periodic got %h want period 8", hist);
    else n_pass++;
  endtask
`endif

  initial begin
    rst_n = 1'b0; ch_en = '1; duty_wr = 1'b0; duty_ch = '0; duty_val = '0;
    top_wr = 1'b0; top_val = '0; center_mode = 1'b0;
    model_reset();
    test_reset();
    test_patterns();
    test_midwrite();
    test_enable();
    test_top0();
    test_random();
    test_mid_reset();
`ifdef PWM_CENTER_ALIGN_EN
    test_center();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
